// File: rtl/mod_n_serial_checker.sv
// ============================================================================
// Module   : mod_n_serial_checker
// Purpose  : Bit-serial running remainder modulo DIVISOR over framed operands,
//            with end-of-frame divisible flag and done pulse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mod_n_serial_checker #(
    parameter int DIVISOR   = 3,
    parameter int LSB_FIRST = 0,
    parameter int CNT_W     = 16,
    localparam int RW       = $clog2(DIVISOR)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             in_last,
    output logic [RW-1:0]    rem,
    output logic             divisible,
    output logic             busy,
    output logic             done,
    output logic             result_div,
    output logic [CNT_W-1:0] bit_count
);

    localparam logic [RW:0] c_div = (RW+1)'(DIVISOR);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t           r_state;
    logic [RW-1:0]    r_rem;
    logic [RW-1:0]    r_weight;
    logic [CNT_W-1:0] r_cnt;
    logic             r_done;
    logic             r_result;

    logic             w_accept;
    logic [RW-1:0]    w_rem_base;
    logic [RW-1:0]    w_weight_base;
    logic [CNT_W-1:0] w_cnt_base;
    logic [RW-1:0]    w_rem_next;
    logic [RW-1:0]    w_weight_next;
    logic [CNT_W-1:0] w_cnt_next;

    // A start cycle updates from the cleared frame values, not the old ones.
    assign w_accept      = in_valid & ((r_state == ACTIVE) | start);
    assign w_rem_base    = start ? '0 : r_rem;
    assign w_weight_base = start ? RW'(1) : r_weight;
    assign w_cnt_base    = start ? '0 : r_cnt;
    assign w_cnt_next    = (&w_cnt_base) ? w_cnt_base : w_cnt_base + CNT_W'(1);

    generate
        if (LSB_FIRST != 0) begin : g_lsb
            logic [RW:0] w_sum;
            logic [RW:0] w_dbl;
            assign w_sum         = {1'b0, w_rem_base} + (in_bit ? {1'b0, w_weight_base} : '0);
            assign w_rem_next    = (w_sum >= c_div) ? RW'(w_sum - c_div) : RW'(w_sum);
            assign w_dbl         = {w_weight_base, 1'b0};
            assign w_weight_next = (w_dbl >= c_div) ? RW'(w_dbl - c_div) : RW'(w_dbl);
        end else begin : g_msb
            logic [RW:0] w_dbl;
            assign w_dbl         = {w_rem_base, in_bit};
            assign w_rem_next    = (w_dbl >= c_div) ? RW'(w_dbl - c_div) : RW'(w_dbl);
            assign w_weight_next = w_weight_base;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_rem    <= '0;
            r_weight <= RW'(1);
            r_cnt    <= '0;
            r_done   <= 1'b0;
            r_result <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_rem    <= w_rem_next;
                r_weight <= w_weight_next;
                r_cnt    <= w_cnt_next;
                if (in_last) begin
                    r_state  <= IDLE;
                    r_done   <= 1'b1;
                    r_result <= (w_rem_next == '0);
                end else begin
                    r_state <= ACTIVE;
                end
            end else if (start) begin
                r_state  <= ACTIVE;
                r_rem    <= '0;
                r_weight <= RW'(1);
                r_cnt    <= '0;
            end
        end
    end

    assign rem        = r_rem;
    assign divisible  = (r_rem == '0);
    assign busy       = (r_state == ACTIVE);
    assign done       = r_done;
    assign result_div = r_result;
    assign bit_count  = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_mod_n_serial_checker.sv
// ============================================================================
// Module   : tb_mod_n_serial_checker
// Purpose  : Self-checking bench; four configurations share one input stream.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mod_n_serial_checker;

    localparam int ND = 4;
    localparam int DIVS [ND] = '{3, 5, 7, 3};
    localparam int LSBS [ND] = '{0, 1, 0, 0};
    localparam int CNTS [ND] = '{16, 16, 16, 3};

    logic clk;
    logic reset_n;
    logic start;
    logic in_valid;
    logic in_bit;
    logic in_last;

    logic [7:0]  rem_o  [ND];
    logic [15:0] cnt_o  [ND];
    logic        div_o  [ND];
    logic        busy_o [ND];
    logic        done_o [ND];
    logic        res_o  [ND];

    for (genvar i = 0; i < ND; i++) begin : g_dut
        localparam int RWI = $clog2(DIVS[i]);
        logic [RWI-1:0]     rem_w;
        logic [CNTS[i]-1:0] cnt_w;
        mod_n_serial_checker #(
            .DIVISOR  (DIVS[i]),
            .LSB_FIRST(LSBS[i]),
            .CNT_W    (CNTS[i])
        ) u_dut (
            .clk       (clk),
            .reset_n   (reset_n),
            .start     (start),
            .in_valid  (in_valid),
            .in_bit    (in_bit),
            .in_last   (in_last),
            .rem       (rem_w),
            .divisible (div_o[i]),
            .busy      (busy_o[i]),
            .done      (done_o[i]),
            .result_div(res_o[i]),
            .bit_count (cnt_w)
        );
        assign rem_o[i] = 8'(rem_w);
        assign cnt_o[i] = 16'(cnt_w);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the operand bits of the current/most recent frame.
    bit q[$];
    bit m_active;
    bit m_done;
    bit m_res [ND];
    int n_assert = 0;
    int n_fail   = 0;

    function automatic longint unsigned frame_value(input bit lsb);
        longint unsigned v = 0;
        for (int k = 0; k < q.size(); k++) begin
            if (lsb) v = v | (longint'(q[k]) << k);
            else     v = (v << 1) | longint'(q[k]);
        end
        return v;
    endfunction

    task automatic chk(input string tag, input int d, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s dut%0d observed=%0d expected=%0d", tag, d, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < ND; i++) begin
            longint unsigned er;
            int cmax;
            er   = frame_value(LSBS[i] != 0) % longint'(DIVS[i]);
            cmax = (1 << CNTS[i]) - 1;
            chk("rem",        i, rem_o[i],  er);
            chk("divisible",  i, div_o[i],  64'(er == 0));
            chk("busy",       i, busy_o[i], 64'(m_active));
            chk("done",       i, done_o[i], 64'(m_done));
            chk("result_div", i, res_o[i],  64'(m_res[i]));
            chk("bit_count",  i, cnt_o[i],  (q.size() > cmax) ? cmax : q.size());
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_active = 0;
        m_done   = 0;
        for (int i = 0; i < ND; i++) m_res[i] = 0;
    endtask

    task automatic model(input logic s, input logic v, input logic b, input logic l);
        m_done = 0;
        if (v && (m_active || s)) begin
            if (s) q.delete();
            q.push_back(b);
            if (l) begin
                m_active = 0;
                m_done   = 1;
                for (int i = 0; i < ND; i++)
                    m_res[i] = ((frame_value(LSBS[i] != 0) % longint'(DIVS[i])) == 0);
            end else begin
                m_active = 1;
            end
        end else if (s) begin
            q.delete();
            m_active = 1;
        end
    endtask

    task automatic step(input logic s, input logic v, input logic b, input logic l);
        start = s; in_valid = v; in_bit = b; in_last = l;
        model(s, v, b, l);
        @(posedge clk);
        #1;
        start = 0; in_valid = 0; in_bit = 0; in_last = 0;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0);
    endtask

    initial begin
        start = 0; in_valid = 0; in_bit = 0; in_last = 0;
        reset_n = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        reset_n = 1;
        idle(1);

        // Value 6, MSB first
        step(1, 1, 1, 0);
        step(0, 1, 1, 0);
        step(0, 1, 0, 1);
        chk("tp6_result", 0, res_o[0], 1);
        chk("tp6_count",  0, cnt_o[0], 3);
        idle(1);

        // Value 11 with two-cycle gaps
        step(1, 1, 1, 0); idle(2);
        step(0, 1, 0, 0); idle(2);
        step(0, 1, 1, 0); idle(2);
        step(0, 1, 1, 1); idle(2);
        chk("tp11_rem_hold", 0, rem_o[0], 2);
        chk("tp11_result",   0, res_o[0], 0);

        // LSB-first 13 then 10 (back-to-back starts in done cycle)
        step(1, 1, 1, 0); step(0, 1, 0, 0); step(0, 1, 1, 0); step(0, 1, 1, 1);
        chk("tp13_rem", 1, rem_o[1], 3);
        step(1, 1, 0, 0); step(0, 1, 1, 0); step(0, 1, 0, 0); step(0, 1, 1, 1);
        chk("tp10_rem",    1, rem_o[1], 0);
        chk("tp10_result", 1, res_o[1], 1);
        idle(1);

        // Abort mid-frame with a new start, then value 7
        step(1, 1, 1, 0); step(0, 1, 1, 0);
        step(1, 1, 1, 0); step(0, 1, 1, 0); step(0, 1, 1, 1);
        chk("tp7_rem",    2, rem_o[2], 0);
        chk("tp7_result", 2, res_o[2], 1);
        chk("tp7_count",  2, cnt_o[2], 3);

        // Single-bit frames back to back
        step(1, 1, 1, 1); step(1, 1, 0, 1); idle(1);

        // Asynchronous reset mid-frame
        step(1, 1, 1, 0); step(0, 1, 0, 0);
        #3;
        reset_n = 0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        reset_n = 1;
        step(0, 1, 1, 1);
        step(1, 1, 1, 0); step(0, 1, 0, 0); step(0, 1, 0, 1);
        idle(1);

        // 1023 as ten ones: counter saturation on the narrow-counter instance
        step(1, 1, 1, 0);
        for (int k = 0; k < 8; k++) step(0, 1, 1, 0);
        step(0, 1, 1, 1);
        chk("sat_count",  3, cnt_o[3], 7);
        chk("sat_rem",    3, rem_o[3], 0);
        chk("sat_result", 3, res_o[3], 1);
        idle(1);

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            logic s, v, b, l;
            s = ($urandom_range(0, 11) == 0);
            v = ($urandom_range(0, 2) != 0);
            b = 1'($urandom_range(0, 1));
            l = ($urandom_range(0, 9) == 0) || (q.size() >= 40);
            step(s, v, b, l);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
